// File: rtl/usb_pkg.sv
// Shared types and constants for the USB serial transmit path.
// Optional feature macro used by the bit stuffer: BIT_STUFF_STATS_EN.
package usb_pkg;

    typedef enum logic [1:0] {IDLE, SEND, STUFF} stuff_state_t;

    localparam int   STUFF_LEN_DEFAULT = 6;
    localparam logic NRZI_J = 1'b1;
    localparam logic NRZI_K = 1'b0;

    // NRZI: a raw 0 toggles the line, a raw 1 holds it.
    function automatic logic nrzi_next(input logic level, input logic raw_bit);
        return raw_bit ? level : ~level;
    endfunction

endpackage

// File: rtl/bit_stuff_nrzi_if.sv
// Upstream bit stream plus downstream NRZI line pair of the bit stuffer.
// stuff_count exists only when BIT_STUFF_STATS_EN is defined.
interface bit_stuff_nrzi_if;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_sending;
`ifdef BIT_STUFF_STATS_EN
    logic [7:0] stuff_count;
`endif

    // Upstream source / observer side.
    modport master (
`ifdef BIT_STUFF_STATS_EN
        input  stuff_count,
`endif
        output in_bit,
        output in_valid,
        input  in_ready,
        input  out_bit,
        input  out_sending
    );

    // Bit stuffer side.
    modport slave (
`ifdef BIT_STUFF_STATS_EN
        output stuff_count,
`endif
        input  in_bit,
        input  in_valid,
        output in_ready,
        output out_bit,
        output out_sending
    );
endinterface

// File: rtl/bit_stuff_ctr.sv
// Ones-run counter for the bit stuffer. Saturates at STUFF_LEN, never wraps.
// o_stuff_now flags that this cycle's update brings the run to STUFF_LEN.
module bit_stuff_ctr #(
    parameter int STUFF_LEN = 6,
    parameter int INIT_ONES = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,   // raw 0 accepted or stuffed bit sent
    input  logic i_inc,     // raw 1 accepted
    input  logic i_init,    // packet boundary: prior run is INIT_ONES
    output logic o_stuff_now
);
    localparam int             W       = $clog2(STUFF_LEN + 1);
    localparam logic [W-1:0]   LP_LEN  = W'(STUFF_LEN);
    localparam logic [W-1:0]   LP_INIT = W'(INIT_ONES);

    logic [W-1:0] r_count;
    logic [W-1:0] w_base;
    logic [W-1:0] w_next;

    // Next run length: pick the prior run, then clear or increment it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_base = i_init ? LP_INIT : r_count;
        w_next = w_base;
        if (i_clear)
            w_next = '0;
        else if (i_inc && (w_base != LP_LEN))
            w_next = w_base + W'(1);
    end

    // Run-length register.
    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_reset)
            r_count <= LP_INIT;
        else
            r_count <= w_next;
    end

    assign o_stuff_now = (w_next == LP_LEN);
endmodule

// File: rtl/bit_stuff_nrzi.sv
// Bit stuffer + NRZI encoder feeding the DP/DM line encoder.
// Inserts a stuffed 0 after STUFF_LEN consecutive raw 1s, then NRZI-encodes.
// Define BIT_STUFF_STATS_EN to add the saturating per-packet stuff_count.
module bit_stuff_nrzi
    import usb_pkg::*;
#(
    parameter int   STUFF_LEN  = STUFF_LEN_DEFAULT,
    parameter logic INIT_LEVEL = NRZI_K,
    parameter int   INIT_ONES  = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    bit_stuff_nrzi_if.slave  io_bus
);
    stuff_state_t r_state;
    logic         r_level;
    logic         r_out_bit;
    logic         r_out_sending;
`ifdef BIT_STUFF_STATS_EN
    logic [7:0]   r_stuff_count;
`endif

    logic w_ready;
    logic w_accept;
    logic w_prior_level;
    logic w_new_level;
    logic w_stuff_now;

    assign w_ready  = (r_state != STUFF);
    assign w_accept = io_bus.in_valid & w_ready;

    // A packet's first bit is encoded against the SYNC-end level.
    always_comb begin
        w_prior_level = (r_state == IDLE) ? INIT_LEVEL : r_level;
        w_new_level   = nrzi_next(w_prior_level, io_bus.in_bit);
    end

    bit_stuff_ctr #(
        .STUFF_LEN (STUFF_LEN),
        .INIT_ONES (INIT_ONES)
    ) u_ctr (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     ((w_accept & ~io_bus.in_bit) | (r_state == STUFF)),
        .i_inc       (w_accept & io_bus.in_bit),
        .i_init      (r_state == IDLE),
        .o_stuff_now (w_stuff_now)
    );

    // Packet FSM with registered line outputs and NRZI level.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_level       <= INIT_LEVEL;
            r_out_bit     <= INIT_LEVEL;
            r_out_sending <= 1'b0;
`ifdef BIT_STUFF_STATS_EN
            r_stuff_count <= 8'd0;
`endif
        end else begin
            case (r_state)
                IDLE, SEND: begin
                    if (io_bus.in_valid) begin
                        r_level       <= w_new_level;
                        r_out_bit     <= w_new_level;
                        r_out_sending <= 1'b1;
                        r_state       <= w_stuff_now ? STUFF : SEND;
`ifdef BIT_STUFF_STATS_EN
                        if (r_state == IDLE)
                            r_stuff_count <= 8'd0;
`endif
                    end else begin
                        r_out_sending <= 1'b0;
                        r_state       <= IDLE;
                        if (r_state == IDLE)
                            r_level <= INIT_LEVEL;
                    end
                end
                STUFF: begin
                    r_level       <= ~r_level;
                    r_out_bit     <= ~r_level;
                    r_out_sending <= 1'b1;
                    r_state       <= SEND;
`ifdef BIT_STUFF_STATS_EN
                    if (r_stuff_count != 8'hFF)
                        r_stuff_count <= r_stuff_count + 8'd1;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.in_ready    = w_ready;
    assign io_bus.out_bit     = r_out_bit;
    assign io_bus.out_sending = r_out_sending;
`ifdef BIT_STUFF_STATS_EN
    assign io_bus.stuff_count = r_stuff_count;
`endif
endmodule

// File: tb/tb_bit_stuff_nrzi.sv
// Directed bench for bit_stuff_nrzi: table of per-cycle vectors plus
// hand-written reset sequences. Checks stuff_count when BIT_STUFF_STATS_EN is defined.
module tb_bit_stuff_nrzi;

    typedef struct {
        logic in_bit;
        logic in_valid;
        logic exp_ready;   // in_ready before the edge
        logic chk_bit;     // out_bit only meaningful while sending
        logic exp_bit;
        logic exp_send;
        int   exp_cnt;     // -1 = not checked
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    bit_stuff_nrzi_if bus ();

    bit_stuff_nrzi dut (
        .i_clock (clock),
        .i_reset (reset),
        .io_bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic b, input logic v, input logic rdy,
                                input logic cb, input logic eb, input logic s, input int cnt);
        vec_t r;
        r.in_bit = b; r.in_valid = v; r.exp_ready = rdy;
        r.chk_bit = cb; r.exp_bit = eb; r.exp_send = s; r.exp_cnt = cnt;
        return r;
    endfunction

    // One clock cycle: drive, check in_ready, clock, check registered outputs.
    task automatic run_row(input vec_t v, input string tag);
        bus.in_bit   = v.in_bit;
        bus.in_valid = v.in_valid;
        #1;
        check({tag, " in_ready"}, 8'(bus.in_ready), 8'(v.exp_ready));
        @(posedge clock);
        #1;
        check({tag, " out_sending"}, 8'(bus.out_sending), 8'(v.exp_send));
        if (v.chk_bit)
            check({tag, " out_bit"}, 8'(bus.out_bit), 8'(v.exp_bit));
`ifdef BIT_STUFF_STATS_EN
        if (v.exp_cnt >= 0)
            check({tag, " stuff_count"}, bus.stuff_count, 8'(v.exp_cnt));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Raw 0,0,0 from IDLE: toggles 1,0,1
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, -1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, -1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, -1));
        // Raw 1x5 from IDLE: run of 6 with INIT_ONES=1, stuff toggles to 1
        for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1));
        // Raw 0 then 1x7: one stall, stuffed 0, then 7th one holds 0
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0));
        for (int k = 0; k < 6; k++) vecs.push_back(mk(1, 1, 1, 1, 1, 1, -1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, -1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1));
        // Raw 0,1x6 then in_valid low: stuff still emitted, then sending drops
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0));
        for (int k = 0; k < 6; k++) vecs.push_back(mk(1, 1, 1, 1, 1, 1, -1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1));

        // Reset held two cycles
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset out_sending", 8'(bus.out_sending), 8'd0);
        check("reset out_bit", 8'(bus.out_bit), 8'd0);
        check("reset in_ready", 8'(bus.in_ready), 8'd1);
`ifdef BIT_STUFF_STATS_EN
        check("reset stuff_count", bus.stuff_count, 8'd0);
`endif
        reset = 1'b0;

        foreach (vecs[i])
            run_row(vecs[i], $sformatf("row%0d", i));

        // Reset in the middle of a run of 5 ones
        for (int k = 0; k < 4; k++)
            run_row(mk(1, 1, 1, 1, 0, 1, -1), $sformatf("pre_reset%0d", k));
        bus.in_bit   = 1'b1;
        bus.in_valid = 1'b1;
        reset        = 1'b1;
        @(posedge clock);
        #1;
        check("midreset out_sending", 8'(bus.out_sending), 8'd0);
        check("midreset in_ready", 8'(bus.in_ready), 8'd1);
`ifdef BIT_STUFF_STATS_EN
        check("midreset stuff_count", bus.stuff_count, 8'd0);
`endif
        reset = 1'b0;
        run_row(mk(0, 0, 1, 0, 0, 0, -1), "post_reset_idle");
        // Fresh packet: level starts at 0 and the run starts at 1
        for (int k = 0; k < 5; k++)
            run_row(mk(1, 1, 1, 1, 0, 1, 0), $sformatf("post_reset%0d", k));
        run_row(mk(0, 0, 0, 1, 1, 1, 1), "post_reset_stuff");
        run_row(mk(0, 0, 1, 0, 0, 0, 1), "post_reset_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
